// File: rtl/lcd_bus_scheduler.sv
// Round-robin owner of the HD44780 character-LCD bus; sequences each byte through setup/enable timing.
// Define LCD_INIT_SEQ_EN to issue the power-on command sequence (0x38,0x0C,0x01,0x06) before serving requesters.
module lcd_bus_scheduler #(
    parameter int EN_HIGH_CYCLES = 500,
    parameter int EN_LOW_CYCLES  = 500,
    parameter int CLEAR_CYCLES   = 2000
) (
    input  logic       clk_1MHz,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       grant_id
);

    localparam int MAX_HL     = (EN_HIGH_CYCLES > EN_LOW_CYCLES) ? EN_HIGH_CYCLES : EN_LOW_CYCLES;
    localparam int MAX_CYCLES = (MAX_HL > CLEAR_CYCLES) ? MAX_HL : CLEAR_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] HI_LAST  = CW'(EN_HIGH_CYCLES - 1);
    localparam logic [CW-1:0] LO_LAST  = CW'(EN_LOW_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HI,
        EN_LO
`ifdef LCD_INIT_SEQ_EN
        ,
        INIT
`endif
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          grant0;
    logic          grant1;
    logic          long_low;
    logic [CW-1:0] lo_last;

    // On a tie the requester that did not win last time gets the bus.
    assign grant0     = req0_valid && (!req1_valid || last_grant);
    assign grant1     = req1_valid && (!req0_valid || !last_grant);
    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;
    assign busy       = (state != IDLE);
    assign lcd_rw     = 1'b0;

    // Clear-display and return-home need the long settle time after the strobe.
    assign long_low = !lcd_rs && ((lcd_data == 8'h01) || (lcd_data == 8'h02));
    assign lo_last  = long_low ? CLR_LAST : LO_LAST;

`ifdef LCD_INIT_SEQ_EN
    logic [1:0] init_idx;
    logic       init_active;
    logic [7:0] init_cmd;

    always_comb begin
        case (init_idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    end
`endif

    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
`ifdef LCD_INIT_SEQ_EN
            state       <= INIT;
            init_idx    <= 2'd0;
            init_active <= 1'b1;
`else
            state       <= IDLE;
`endif
            cnt         <= '0;
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            lcd_rs      <= 1'b0;
            lcd_en      <= 1'b0;
            lcd_data    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        lcd_rs     <= grant0 ? req0_rs : req1_rs;
                        lcd_data   <= grant0 ? req0_data : req1_data;
                        grant_id   <= grant1;
                        last_grant <= grant1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    lcd_en <= 1'b1;
                    cnt    <= '0;
                    state  <= EN_HI;
                end
                EN_HI: begin
                    if (cnt == HI_LAST) begin
                        lcd_en <= 1'b0;
                        cnt    <= '0;
                        state  <= EN_LO;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                EN_LO: begin
                    if (cnt == lo_last) begin
                        cnt <= '0;
`ifdef LCD_INIT_SEQ_EN
                        if (init_active && (init_idx != 2'd3)) begin
                            init_idx <= init_idx + 2'd1;
                            state    <= INIT;
                        end else begin
                            init_active <= 1'b0;
                            state       <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef LCD_INIT_SEQ_EN
                INIT: begin
                    lcd_rs   <= 1'b0;
                    lcd_data <= init_cmd;
                    state    <= SETUP;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
